// File: rtl/rx_frame_ctrl.sv
// rx_frame_ctrl: sync hunt, length/payload framing and receiver flush.
// Define FRAME_CHECKSUM_EN to append and verify a mod-256 checksum byte.
module rx_frame_ctrl #(
  parameter logic [15:0] SYNC_WORD   = 16'hA5C3,
  parameter int          MAX_LEN     = 32,
  parameter int          TIMEOUT_CYC = 1024,
  parameter int          FLUSH_CYC   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       bit_in,
  input  logic       bit_valid,
  output logic       rx_rst,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  input  logic       byte_ready,
  output logic       frame_start,
  output logic       frame_done,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic       busy
);
  localparam int BW = $clog2(MAX_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int FW = $clog2(FLUSH_CYC + 1);
  localparam logic [BW-1:0] B_ONE = BW'(1);
  localparam logic [TW-1:0] T_ONE = TW'(1);
  localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT_CYC - 1);
  localparam logic [FW-1:0] F_ONE = FW'(1);
  localparam logic [FW-1:0] F_MAX = FW'(FLUSH_CYC - 1);
  localparam logic [7:0]    L_MAX = 8'(MAX_LEN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FLUSH,
    S_HUNT,
    S_LEN,
    S_PAY,
`ifdef FRAME_CHECKSUM_EN
    S_CHK,
`endif
    S_DONE,
    S_ERR
  } state_t;

  state_t state, nxt;

  logic [15:0]   sync_sr;
  logic [6:0]    dsh;
  logic [2:0]    bitcnt;
  logic [BW-1:0] len_q;
  logic [BW-1:0] bcnt;
  logic [TW-1:0] tmo;
  logic [FW-1:0] fcnt;
`ifdef FRAME_CHECKSUM_EN
  logic [7:0]    csum;
`endif

  logic [15:0] sync_nx;
  logic [7:0]  byte_nx;
  logic        last_bit;
  logic        last_byte;
  logic        tmo_hit;
  logic        in_frame;
  logic        sync_hit;
  logic        ld_byte;
  logic        go_err;
  logic [1:0]  err_nx;

  assign sync_nx   = {sync_sr[14:0], bit_in};
  assign byte_nx   = {dsh, bit_in};
  assign last_bit  = bit_valid && (bitcnt == 3'd7);
  assign last_byte = (bcnt == len_q - B_ONE);
  assign tmo_hit   = !bit_valid && (tmo == T_MAX);
`ifdef FRAME_CHECKSUM_EN
  assign in_frame  = (state == S_LEN) || (state == S_PAY) ||
                     (state == S_CHK);
`else
  assign in_frame  = (state == S_LEN) || (state == S_PAY);
`endif

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= nxt;
  end

  // next state, control strobes and state-decoded outputs
  always_comb begin
    nxt        = state;
    sync_hit   = 1'b0;
    ld_byte    = 1'b0;
    go_err     = 1'b0;
    err_nx     = err_code;
    rx_rst     = (state == S_FLUSH);
    frame_done = (state == S_DONE);
    frame_err  = (state == S_ERR);
    busy       = (state != S_IDLE) && (state != S_HUNT);
    if (!enable) begin
      nxt = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE:  nxt = S_FLUSH;
        S_FLUSH: if (fcnt == F_MAX) nxt = S_HUNT;
        S_HUNT: begin
          if (bit_valid && sync_nx == SYNC_WORD) begin
            nxt      = S_LEN;
            sync_hit = 1'b1;
          end
        end
        S_LEN: begin
          if (tmo_hit) begin
            go_err = 1'b1;
            err_nx = 2'd1;
          end else if (last_bit) begin
            if (byte_nx == 8'd0 || byte_nx > L_MAX) begin
              go_err = 1'b1;
              err_nx = 2'd0;
            end else begin
              nxt = S_PAY;
            end
          end
        end
        S_PAY: begin
          if (tmo_hit) begin
            go_err = 1'b1;
            err_nx = 2'd1;
          end else if (last_bit) begin
            if (byte_valid && !byte_ready) begin
              go_err = 1'b1;
              err_nx = 2'd2;
            end else begin
              ld_byte = 1'b1;
`ifdef FRAME_CHECKSUM_EN
              if (last_byte) nxt = S_CHK;
`else
              if (last_byte) nxt = S_DONE;
`endif
            end
          end
        end
`ifdef FRAME_CHECKSUM_EN
        S_CHK: begin
          if (tmo_hit) begin
            go_err = 1'b1;
            err_nx = 2'd1;
          end else if (last_bit) begin
            if (byte_nx == csum) begin
              nxt = S_DONE;
            end else begin
              go_err = 1'b1;
              err_nx = 2'd3;
            end
          end
        end
`endif
        S_DONE:  nxt = S_FLUSH;
        S_ERR:   nxt = S_FLUSH;
        default: nxt = S_IDLE;
      endcase
      if (go_err) nxt = S_ERR;
    end
  end

  // framing datapath, output register and counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_sr     <= '0;
      dsh         <= '0;
      bitcnt      <= '0;
      len_q       <= '0;
      bcnt        <= '0;
      tmo         <= '0;
      fcnt        <= '0;
      byte_out    <= '0;
      byte_valid  <= 1'b0;
      frame_start <= 1'b0;
      err_code    <= '0;
`ifdef FRAME_CHECKSUM_EN
      csum        <= '0;
`endif
    end else begin
      frame_start <= sync_hit;
      if (go_err) err_code <= err_nx;
      if (!enable)
        byte_valid <= 1'b0;
      else if (ld_byte) begin
        byte_out   <= byte_nx;
        byte_valid <= 1'b1;
      end else if (byte_valid && byte_ready)
        byte_valid <= 1'b0;
      if (state == S_IDLE || state == S_FLUSH)
        sync_sr <= '0;
      else if (state == S_HUNT && bit_valid)
        sync_sr <= sync_nx;
      if (state == S_FLUSH) fcnt <= fcnt + F_ONE;
      else                  fcnt <= '0;
      if (sync_hit) begin
        dsh    <= '0;
        bitcnt <= '0;
        bcnt   <= '0;
        tmo    <= '0;
`ifdef FRAME_CHECKSUM_EN
        csum   <= '0;
`endif
      end else if (in_frame) begin
        if (bit_valid) begin
          dsh    <= byte_nx[6:0];
          bitcnt <= bitcnt + 3'd1;
          tmo    <= '0;
        end else if (!tmo_hit) begin
          tmo <= tmo + T_ONE;
        end
      end
      if (state == S_LEN && last_bit)
        len_q <= byte_nx[BW-1:0];
      if (ld_byte) begin
        bcnt <= bcnt + B_ONE;
`ifdef FRAME_CHECKSUM_EN
        csum <= csum + byte_nx;
`endif
      end
    end
  end

endmodule
